// File: rtl/tlb_inv_seq_pkg.sv
// Shared definitions for the INVTLB sequencer.
//  - inv_op_e : INVTLB op codes 0..6 (anything above INV_GASID_VA is illegal)
//  - state_e  : sequencer FSM states
//  - PS_4K/PS_4M : page-size encodings found in the TLB ps field
//  - op_legal : true for op codes the sequencer will scan for
package tlb_inv_seq_pkg;

   typedef enum logic [4:0] {
      INV_ALL0     = 5'd0,
      INV_ALL1     = 5'd1,
      INV_GLB      = 5'd2,
      INV_NGLB     = 5'd3,
      INV_ASID     = 5'd4,
      INV_ASID_VA  = 5'd5,
      INV_GASID_VA = 5'd6
   } inv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_e;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_4M = 6'd21;

   function automatic logic op_legal(input logic [4:0] op);
      return op <= 5'(INV_GASID_VA);
   endfunction

endpackage

// File: rtl/tlb_inv_seq_dec.sv
// Binary-to-one-hot decoder: selects the TLB row currently being scanned.
//  in  : IN_W-bit index
//  out : 2**IN_W one-hot row select
module decoder_4_16 #(
   parameter int IN_W = 4
) (
   input  logic [IN_W-1:0]      in,
   output logic [(1<<IN_W)-1:0] out
);

   for (genvar i = 0; i < (1 << IN_W); i++) begin : g_row
      assign out[i] = (in == IN_W'(i));
   end

endmodule

// File: rtl/tlb_inv_seq.sv
// INVTLB sequencer. After accepting a request it visits every TLB entry once,
// one per cycle, through the TLB's combinational read port, and pulses the
// clear strobe of every valid entry that matches the selected op.
//  clk, resetn                : clock, async active-low reset
//  inv_valid/inv_ready        : request handshake (ready only in IDLE)
//  inv_op/inv_asid/inv_vppn   : INVTLB operands, latched at accept
//  busy                       : scan in progress (pipeline stalls, TLB writes blocked)
//  done/op_err/inv_hits       : completion pulse, illegal-op pulse, cleared-entry count
//  r_index, r_e/r_g/r_asid/r_vppn/r_ps : TLB read port
//  clr_we                     : one-hot clear-E strobe, applied at next clk edge
module tlb_inv_seq
   import tlb_inv_seq_pkg::*;
#(
   parameter int TLBNUM = 16,
   parameter int IDX_W  = 4,
   parameter int ASID_W = 10,
   parameter int VPPN_W = 19
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inv_valid,
   output logic              inv_ready,
   input  logic [4:0]        inv_op,
   input  logic [ASID_W-1:0] inv_asid,
   input  logic [VPPN_W-1:0] inv_vppn,
   output logic              busy,
   output logic              done,
   output logic              op_err,
   output logic [IDX_W:0]    inv_hits,
   output logic [IDX_W-1:0]  r_index,
   input  logic              r_e,
   input  logic              r_g,
   input  logic [ASID_W-1:0] r_asid,
   input  logic [VPPN_W-1:0] r_vppn,
   input  logic [5:0]        r_ps,
   output logic [TLBNUM-1:0] clr_we
);

   // Lowest VPPN bit that still takes part in a 4 MB page compare.
   localparam int HUGE_LO = 9;

   state_e              state, nstate;
   logic [IDX_W-1:0]    cnt;
   logic [IDX_W:0]      hits;
   logic [4:0]          op_q;
   logic [ASID_W-1:0]   asid_q;
   logic [VPPN_W-1:0]   vppn_q;
   logic [TLBNUM-1:0]   dec_out;
   logic                accept, scan, match, hit, asid_eq, vm;

   assign accept = (state == IDLE) & inv_valid;
   assign scan   = (state == SCAN);

   // VA compare: 4 MB pages ignore the VPPN bits below the huge-page boundary.
   assign asid_eq = (asid_q == r_asid);
   assign vm      = (r_ps == PS_4M) ? (vppn_q[VPPN_W-1:HUGE_LO] == r_vppn[VPPN_W-1:HUGE_LO])
                                    : (vppn_q == r_vppn);

   always_comb begin
      match = 1'b0;
      case (op_q)
         INV_ALL0, INV_ALL1: match = 1'b1;
         INV_GLB:            match = r_g;
         INV_NGLB:           match = ~r_g;
         INV_ASID:           match = ~r_g & asid_eq;
         INV_ASID_VA:        match = ~r_g & asid_eq & vm;
         INV_GASID_VA:       match = (r_g | asid_eq) & vm;
         default:            match = 1'b0;
      endcase
   end

   assign hit = scan & match & r_e;

   decoder_4_16 #(.IN_W(IDX_W)) u_clr_dec (
      .in  (cnt),
      .out (dec_out)
   );

   assign clr_we   = dec_out & {TLBNUM{hit}};
   assign r_index  = cnt;
   assign inv_hits = (state == DONE) ? hits : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         cnt    <= '0;
         hits   <= '0;
         op_q   <= '0;
         asid_q <= '0;
         vppn_q <= '0;
      end else begin
         state <= nstate;
         if (accept) begin
            op_q   <= inv_op;
            asid_q <= inv_asid;
            vppn_q <= inv_vppn;
            cnt    <= '0;
            hits   <= '0;
         end else if (scan) begin
            // Natural wrap brings cnt back to 0 exactly as SCAN is left.
            cnt  <= cnt + 1'b1;
            hits <= hits + (IDX_W+1)'(hit);
         end
      end
   end

   always_comb begin
      nstate    = state;
      inv_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      op_err    = 1'b0;
      case (state)
         IDLE: begin
            inv_ready = 1'b1;
            if (inv_valid) nstate = op_legal(inv_op) ? SCAN : ERR;
         end
         SCAN: begin
            busy = 1'b1;
            if (cnt == IDX_W'(TLBNUM-1)) nstate = DONE;
         end
         DONE: begin
            done   = 1'b1;
            nstate = IDLE;
         end
         ERR: begin
            done   = 1'b1;
            op_err = 1'b1;
            nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Bench for tlb_inv_seq: a small TLB array behind the read port, a request-level
// model that predicts every cycle's outputs from the accept point, and directed
// scenarios with literal expectations on hit counts, latency and surviving E bits.
module tb_tlb_inv_seq;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inv_valid = 1'b0;
   logic        inv_ready;
   logic [4:0]  inv_op = '0;
   logic [9:0]  inv_asid = '0;
   logic [18:0] inv_vppn = '0;
   logic        busy, done, op_err;
   logic [4:0]  inv_hits;
   logic [3:0]  r_index;
   logic        r_e, r_g;
   logic [9:0]  r_asid;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [15:0] clr_we;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   tlb_inv_seq dut (
      .clk(clk), .resetn(resetn), .inv_valid(inv_valid), .inv_ready(inv_ready),
      .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .busy(busy),
      .done(done), .op_err(op_err), .inv_hits(inv_hits), .r_index(r_index),
      .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn), .r_ps(r_ps),
      .clr_we(clr_we)
   );

   // ---------------- TLB storage ----------------
   logic        tlb_e    [16];
   logic        tlb_g    [16];
   logic [9:0]  tlb_asid [16];
   logic [18:0] tlb_vppn [16];
   logic [5:0]  tlb_ps   [16];

   assign r_e    = tlb_e[r_index];
   assign r_g    = tlb_g[r_index];
   assign r_asid = tlb_asid[r_index];
   assign r_vppn = tlb_vppn[r_index];
   assign r_ps   = tlb_ps[r_index];

   always @(posedge clk)
      for (int k = 0; k < 16; k++)
         if (clr_we[k]) tlb_e[k] <= 1'b0;

   task automatic tlb_fill();
      for (int k = 0; k < 16; k++) begin
         tlb_e[k] <= 1'b1; tlb_g[k] <= 1'b0; tlb_asid[k] <= '0;
         tlb_vppn[k] <= '0; tlb_ps[k] <= 6'd12;
      end
   endtask

   task automatic tlb_set(input int k, input logic e, input logic g, input logic [9:0] a,
                          input logic [18:0] v, input logic [5:0] ps);
      tlb_e[k] <= e; tlb_g[k] <= g; tlb_asid[k] <= a; tlb_vppn[k] <= v; tlb_ps[k] <= ps;
   endtask

   function automatic logic [15:0] e_vec();
      logic [15:0] v;
      for (int k = 0; k < 16; k++) v[k] = tlb_e[k];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- request-level model ----------------
   // Entries are each visited once and only this op clears them, so the set of
   // entries to clear can be decided from a snapshot taken at accept.
   function automatic logic rule(input logic [4:0] op, input logic [9:0] a,
                                 input logic [18:0] v, input int k);
      logic same_as, same_va;
      same_as = (tlb_asid[k] == a);
      if (tlb_ps[k] == 6'd21) same_va = (tlb_vppn[k] >> 9) == (v >> 9);
      else                    same_va = (tlb_vppn[k] == v);
      if (op <= 1) return 1'b1;
      if (op == 2) return tlb_g[k];
      if (op == 3) return !tlb_g[k];
      if (op == 4) return !tlb_g[k] && same_as;
      if (op == 5) return !tlb_g[k] && same_as && same_va;
      return (tlb_g[k] || same_as) && same_va;
   endfunction

   int          mode = 0;   // 0 idle, 1 legal op in flight, 2 illegal op
   int          t = 0;      // cycles since accept (1 = first cycle after accept)
   logic [15:0] exp_set;
   int          exp_hits;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mode = 0; t = 0;
      end else if (mode == 0) begin
         if (inv_valid) begin
            exp_set = '0; exp_hits = 0;
            for (int k = 0; k < 16; k++)
               if (inv_op <= 6 && tlb_e[k] && rule(inv_op, inv_asid, inv_vppn, k)) begin
                  exp_set[k] = 1'b1; exp_hits++;
               end
            t = 1;
            mode = (inv_op <= 6) ? 1 : 2;
         end
      end else begin
         t++;
         if (mode == 1 && t == 18) mode = 0;
         if (mode == 2 && t == 2)  mode = 0;
      end
   end

   always @(negedge clk) begin
      logic        e_busy, e_done;
      logic [15:0] e_clr;
      e_busy = (mode == 1 && t <= 16);
      e_done = (mode == 1 && t == 17) || mode == 2;
      e_clr  = (e_busy && exp_set[t-1]) ? (16'd1 << (t-1)) : 16'd0;
      chk("inv_ready", inv_ready, (mode == 0));
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("op_err", op_err, (mode == 2));
      chk("clr_we", clr_we, e_clr);
      chk("r_index", r_index, e_busy ? 32'(t-1) : 32'd0);
      chk("inv_hits", inv_hits, (mode == 1 && t == 17) ? 32'(exp_hits) : 32'd0);
   end

   // ---------------- driver ----------------
   task automatic run_op(input logic [4:0] op, input logic [9:0] a, input logic [18:0] v,
                         input bit hold, output int lat, output logic [4:0] hits,
                         output logic err);
      bit got = 0;
      lat = 0; hits = '0; err = 1'b0;
      @(negedge clk);
      inv_valid = 1'b1; inv_op = op; inv_asid = a; inv_vppn = v;
      @(posedge clk);
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (i == 1) begin
            // Either withdraw the request or keep pushing garbage that must be ignored.
            if (hold) begin inv_op = 5'd9; inv_asid = ~a; inv_vppn = ~v; end
            else inv_valid = 1'b0;
         end
         if (done) begin got = 1; lat = i; hits = inv_hits; err = op_err; end
      end
      inv_valid = 1'b0;
      if (!got) chk("done_timeout", 0, 1);
   endtask

   int          lat;
   logic [4:0]  hits;
   logic        err;

   initial begin
      tlb_fill();
      #1;
      chk("rst_ready", inv_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_clr", clr_we, 0);
      chk("rst_hits", inv_hits, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // 1: everything valid, op0, request held high with junk during the scan
      run_op(5'd0, 10'h0, 19'h0, 1, lat, hits, err);
      chk("t1_lat", lat, 17); chk("t1_hits", hits, 16); chk("t1_err", err, 0);
      chk("t1_e", e_vec(), 16'h0000);

      // 2: op2 clears only global entries 3 and 7
      tlb_fill(); tlb_g[3] <= 1'b1; tlb_g[7] <= 1'b1;
      run_op(5'd2, 10'h0, 19'h0, 0, lat, hits, err);
      chk("t2_hits", hits, 2); chk("t2_e", e_vec(), 16'hFF77);

      // 3: op5 distinguishes vppn 0x1234 from 0x1235 on 4K pages
      tlb_fill();
      for (int k = 0; k < 16; k++) tlb_g[k] <= 1'b1;
      tlb_set(9,  1, 0, 10'h005, 19'h1234, 6'd12);
      tlb_set(10, 1, 0, 10'h005, 19'h1235, 6'd12);
      run_op(5'd5, 10'h005, 19'h1234, 0, lat, hits, err);
      chk("t3_hits", hits, 1); chk("t3_e", e_vec(), 16'hFDFF);

      // 4: op6 on a 4M global page matches on vppn[18:9] only
      tlb_fill();
      for (int k = 0; k < 16; k++) tlb_asid[k] <= 10'h3FF;
      tlb_set(2, 1, 1, 10'h3FF, 19'h12CB, 6'd21);
      tlb_set(5, 1, 0, 10'h003, 19'h12CB, 6'd12);
      run_op(5'd6, 10'h003, 19'h1234, 0, lat, hits, err);
      chk("t4_hits", hits, 1); chk("t4_e", e_vec(), 16'hFFFB);

      // 5: illegal op
      tlb_fill();
      run_op(5'd9, 10'h0, 19'h0, 0, lat, hits, err);
      chk("t5_lat", lat, 1); chk("t5_err", err, 1); chk("t5_hits", hits, 0);
      chk("t5_e", e_vec(), 16'hFFFF);

      // 6: reset in cycle T+5 of an op0 scan
      tlb_fill();
      @(negedge clk);
      inv_valid = 1'b1; inv_op = 5'd0;
      @(posedge clk);
      @(negedge clk);
      inv_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("t6_busy", busy, 0); chk("t6_clr", clr_we, 0); chk("t6_done", done, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      chk("t6_e", e_vec(), 16'hFFF0);
      run_op(5'd1, 10'h0, 19'h0, 0, lat, hits, err);
      chk("t6_lat", lat, 17); chk("t6_hits", hits, 12); chk("t6_e2", e_vec(), 16'h0000);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
